// File: rtl/dnn_accel_core.sv
// dnn_accel_core: a 3x3, 3-channel convolution engine that computes NUM_KERNEL kernels per pass.
// Each output pixel takes an 11-cycle slot: 9 tap reads, one drain cycle, then one packed int8 write.
module dnn_accel_core #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_KERNEL  = 4,
  parameter int NUM_KCPE    = 3,
  parameter int REG_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_BYTE    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
  input  logic [REG_WIDTH-1:0]  i_conf_kernelsize,
  input  logic [REG_WIDTH-1:0]  i_conf_weightinterval,
  input  logic [REG_WIDTH-1:0]  i_conf_kernelshape,
  input  logic [REG_WIDTH-1:0]  i_conf_inputshape,
  input  logic [REG_WIDTH-1:0]  i_conf_inputrstcnt,
  output logic [REG_WIDTH-1:0]  o_conf_status,
  output logic [ADDR_WIDTH-1:0] mem_addr_0,
  output logic [DATA_WIDTH-1:0] mem_idat_0,
  input  logic [DATA_WIDTH-1:0] mem_odat_0,
  output logic [NUM_BYTE-1:0]   mem_wren_0,
  output logic                  mem_enb_0,
  output logic                  mem_rst_0,
  output logic [ADDR_WIDTH-1:0] mem_addr_1,
  output logic [DATA_WIDTH-1:0] mem_idat_1,
  input  logic [DATA_WIDTH-1:0] mem_odat_1,
  output logic [NUM_BYTE-1:0]   mem_wren_1,
  output logic                  mem_enb_1,
  output logic                  mem_rst_1,
  output logic [ADDR_WIDTH-1:0] mem_addr_2,
  output logic [DATA_WIDTH-1:0] mem_idat_2,
  input  logic [DATA_WIDTH-1:0] mem_odat_2,
  output logic [NUM_BYTE-1:0]   mem_wren_2,
  output logic                  mem_enb_2,
  output logic                  mem_rst_2,
  output logic [ADDR_WIDTH-1:0] mem_addr_3,
  output logic [DATA_WIDTH-1:0] mem_idat_3,
  input  logic [DATA_WIDTH-1:0] mem_odat_3,
  output logic [NUM_BYTE-1:0]   mem_wren_3,
  output logic                  mem_enb_3,
  output logic                  mem_rst_3,
  output logic [ADDR_WIDTH-1:0] mem_addr_4,
  output logic [DATA_WIDTH-1:0] mem_idat_4,
  input  logic [DATA_WIDTH-1:0] mem_odat_4,
  output logic [NUM_BYTE-1:0]   mem_wren_4,
  output logic                  mem_enb_4,
  output logic                  mem_rst_4,
  output logic [ADDR_WIDTH-1:0] mem_addr_5,
  output logic [DATA_WIDTH-1:0] mem_idat_5,
  input  logic [DATA_WIDTH-1:0] mem_odat_5,
  output logic [NUM_BYTE-1:0]   mem_wren_5,
  output logic                  mem_enb_5,
  output logic                  mem_rst_5,
  output logic [ADDR_WIDTH-1:0] mem_addr_6,
  output logic [DATA_WIDTH-1:0] mem_idat_6,
  input  logic [DATA_WIDTH-1:0] mem_odat_6,
  output logic [NUM_BYTE-1:0]   mem_wren_6,
  output logic                  mem_enb_6,
  output logic                  mem_rst_6
);

  localparam int NUM_MAC = (NUM_KCPE < NUM_CHANNEL) ? NUM_KCPE : NUM_CHANNEL;
  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (BIT_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -SAT_MAX - 32'sd1;
  localparam logic [3:0] T_DRAIN = 4'd9;
  localparam logic [3:0] T_WRITE = 4'd10;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  function automatic logic signed [31:0] dot_c(input logic [DATA_WIDTH-1:0] d,
                                               input logic [DATA_WIDTH-1:0] w);
    logic signed [BIT_WIDTH-1:0]   a;
    logic signed [BIT_WIDTH-1:0]   b;
    logic signed [2*BIT_WIDTH-1:0] p;
    logic signed [31:0]            s;
    s = 32'sd0;
    for (int c = 0; c < NUM_MAC; c++) begin
      a = d[c*BIT_WIDTH +: BIT_WIDTH];
      b = w[c*BIT_WIDTH +: BIT_WIDTH];
      p = a * b;
      s = s + 32'(p);
    end
    return s;
  endfunction

  function automatic logic [BIT_WIDTH-1:0] sat_add(input logic signed [31:0] acc,
                                                   input logic signed [BIT_WIDTH-1:0] ps,
                                                   input logic en);
    logic signed [31:0] v;
    v = en ? acc + 32'(ps) : acc;
    if (v > SAT_MAX) return SAT_MAX[BIT_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[BIT_WIDTH-1:0];
    else return v[BIT_WIDTH-1:0];
  endfunction

  state_e state_q, state_d;
  logic [3:0]  t_q, t_d;
  logic [31:0] pix_q, pix_d, ox_q, ox_d, oy_q, oy_d;
  logic [15:0] pass_q, pass_d;
  logic signed [31:0] acc_q [NUM_KERNEL];
  logic signed [31:0] acc_d [NUM_KERNEL];
  logic [DATA_WIDTH-1:0] psum_q, psum_d;
  logic        cfg_acc_q, cfg_acc_d;
  logic [31:0] cfg_osize_q, cfg_osize_d, cfg_wint_q, cfg_wint_d, cfg_irst_q, cfg_irst_d;
  logic [15:0] cfg_npass_q, cfg_npass_d, cfg_lg2s_q, cfg_lg2s_d;
  logic [7:0]  cfg_w_q, cfg_w_d;
  logic [3:0]  cfg_kw_q, cfg_kw_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, waddr_q, waddr_d, oaddr_q, oaddr_d;
  logic [DATA_WIDTH-1:0] idat6_q, idat6_d;
  logic [NUM_BYTE-1:0]   wren6_q, wren6_d;
  logic                  enb_q, enb_d;
  logic [REG_WIDTH-1:0]  status_q, status_d;

  logic        start_s, last_pix_s, last_pass_s, run_next_s, wr_s;
  logic [31:0] ow_s, s_s, outn_s, ky_s, kx_s;
  logic [DATA_WIDTH-1:0] wgt_s [NUM_KERNEL];
  logic        unused_s;

  assign wgt_s[0] = mem_odat_1;
  assign wgt_s[1] = mem_odat_2;
  assign wgt_s[2] = mem_odat_3;
  assign wgt_s[3] = mem_odat_4;

  assign start_s     = (state_q == IDLE) && i_conf_ctrl[0];
  assign ow_s        = (({24'd0, cfg_w_q} - {28'd0, cfg_kw_q}) >> cfg_lg2s_q) + 32'd1;
  assign s_s         = 32'd1 << cfg_lg2s_q;
  assign outn_s      = cfg_osize_q + 32'd1;
  assign last_pix_s  = (pix_q == cfg_osize_q);
  assign last_pass_s = (pass_q == cfg_npass_q - 16'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a zero pass count skips straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_conf_ctrl[0]) state_d = (i_conf_kernelsize[31:16] == 16'd0) ? DONE : RUN;
        else                state_d = IDLE;
      end
      RUN: begin
        if (!i_conf_ctrl[0])                                 state_d = IDLE;
        else if (t_q == T_WRITE && last_pix_s && last_pass_s) state_d = DONE;
        else                                                  state_d = RUN;
      end
      DONE: begin
        if (!i_conf_ctrl[0]) state_d = IDLE;
        else                 state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Configuration snapshot, slot/pixel/pass counters, accumulators and held psum
  always_comb begin
    cfg_acc_d   = start_s ? i_conf_ctrl[4]            : cfg_acc_q;
    cfg_osize_d = start_s ? i_conf_outputsize         : cfg_osize_q;
    cfg_npass_d = start_s ? i_conf_kernelsize[31:16]  : cfg_npass_q;
    cfg_w_d     = start_s ? i_conf_inputshape[7:0]    : cfg_w_q;
    cfg_lg2s_d  = start_s ? i_conf_inputshape[31:16]  : cfg_lg2s_q;
    cfg_kw_d    = start_s ? i_conf_kernelshape[7:4]   : cfg_kw_q;
    cfg_wint_d  = start_s ? i_conf_weightinterval     : cfg_wint_q;
    cfg_irst_d  = start_s ? i_conf_inputrstcnt        : cfg_irst_q;
    t_d = t_q; pix_d = pix_q; ox_d = ox_q; oy_d = oy_q; pass_d = pass_q;
    if (state_q != RUN || state_d != RUN) begin
      t_d = 4'd0; pix_d = 32'd0; ox_d = 32'd0; oy_d = 32'd0; pass_d = 16'd0;
    end else if (t_q != T_WRITE) begin
      t_d = t_q + 4'd1;
    end else begin
      t_d = 4'd0;
      if (last_pix_s) begin
        pix_d = 32'd0; ox_d = 32'd0; oy_d = 32'd0; pass_d = pass_q + 16'd1;
      end else begin
        pix_d = pix_q + 32'd1;
        if (ox_q + 32'd1 == ow_s) begin
          ox_d = 32'd0; oy_d = oy_q + 32'd1;
        end else begin
          ox_d = ox_q + 32'd1;
        end
      end
    end
    // Read data trails its address by one cycle, so slot cycle t consumes tap t-1
    psum_d = (state_q == RUN && t_q == 4'd1) ? mem_odat_5 : psum_q;
    for (int n = 0; n < NUM_KERNEL; n++) begin
      if (t_q == 4'd0)         acc_d[n] = 32'sd0;
      else if (t_q <= T_DRAIN) acc_d[n] = acc_q[n] + dot_c(mem_odat_0, wgt_s[n]);
      else                     acc_d[n] = acc_q[n];
    end
  end

  // Output decode from next-cycle counters so every memory-facing output is a flop
  always_comb begin
    run_next_s = (state_d == RUN);
    wr_s       = run_next_s && (t_d == T_WRITE);
    ky_s       = {28'd0, t_d / 4'd3};
    kx_s       = {28'd0, t_d % 4'd3};
    addr0_d    = 32'd0;
    waddr_d    = 32'd0;
    oaddr_d    = 32'd0;
    if (run_next_s) begin
      addr0_d = (oy_d * s_s + ky_s) * {24'd0, cfg_w_q} + ox_d * s_s + kx_s;
      waddr_d = {16'd0, pass_d} * 32'd9 + {28'd0, t_d};
      oaddr_d = {16'd0, pass_d} * outn_s + pix_d;
    end else begin
      addr0_d = 32'd0;
    end
    wren6_d = wr_s ? 4'hF : 4'h0;
    idat6_d = 32'd0;
    if (wr_s) begin
      for (int n = 0; n < NUM_KERNEL; n++)
        idat6_d[n*BIT_WIDTH +: BIT_WIDTH] = sat_add(acc_d[n], psum_q[n*BIT_WIDTH +: BIT_WIDTH], cfg_acc_q);
    end else begin
      idat6_d = 32'd0;
    end
    enb_d    = run_next_s;
    status_d = {30'd0, state_d == DONE, run_next_s};
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q <= 4'd0; pix_q <= 32'd0; ox_q <= 32'd0; oy_q <= 32'd0; pass_q <= 16'd0;
      for (int n = 0; n < NUM_KERNEL; n++) acc_q[n] <= 32'sd0;
      psum_q <= 32'd0;
      cfg_acc_q <= 1'b0; cfg_osize_q <= 32'd0; cfg_npass_q <= 16'd0; cfg_w_q <= 8'd0;
      cfg_lg2s_q <= 16'd0; cfg_kw_q <= 4'd0; cfg_wint_q <= 32'd0; cfg_irst_q <= 32'd0;
      addr0_q <= 32'd0; waddr_q <= 32'd0; oaddr_q <= 32'd0;
      idat6_q <= 32'd0; wren6_q <= 4'h0; enb_q <= 1'b0; status_q <= 32'd0;
    end else begin
      t_q <= t_d; pix_q <= pix_d; ox_q <= ox_d; oy_q <= oy_d; pass_q <= pass_d;
      for (int n = 0; n < NUM_KERNEL; n++) acc_q[n] <= acc_d[n];
      psum_q <= psum_d;
      cfg_acc_q <= cfg_acc_d; cfg_osize_q <= cfg_osize_d; cfg_npass_q <= cfg_npass_d; cfg_w_q <= cfg_w_d;
      cfg_lg2s_q <= cfg_lg2s_d; cfg_kw_q <= cfg_kw_d; cfg_wint_q <= cfg_wint_d; cfg_irst_q <= cfg_irst_d;
      addr0_q <= addr0_d; waddr_q <= waddr_d; oaddr_q <= oaddr_d;
      idat6_q <= idat6_d; wren6_q <= wren6_d; enb_q <= enb_d; status_q <= status_d;
    end
  end

  assign o_conf_status = status_q;
  assign mem_addr_0 = addr0_q;
  assign mem_addr_1 = waddr_q;
  assign mem_addr_2 = waddr_q;
  assign mem_addr_3 = waddr_q;
  assign mem_addr_4 = waddr_q;
  assign mem_addr_5 = oaddr_q;
  assign mem_addr_6 = oaddr_q;
  assign mem_idat_0 = 32'd0;
  assign mem_idat_1 = 32'd0;
  assign mem_idat_2 = 32'd0;
  assign mem_idat_3 = 32'd0;
  assign mem_idat_4 = 32'd0;
  assign mem_idat_5 = 32'd0;
  assign mem_idat_6 = idat6_q;
  assign mem_wren_0 = 4'h0;
  assign mem_wren_1 = 4'h0;
  assign mem_wren_2 = 4'h0;
  assign mem_wren_3 = 4'h0;
  assign mem_wren_4 = 4'h0;
  assign mem_wren_5 = 4'h0;
  assign mem_wren_6 = wren6_q;
  assign mem_enb_0 = enb_q;
  assign mem_enb_1 = enb_q;
  assign mem_enb_2 = enb_q;
  assign mem_enb_3 = enb_q;
  assign mem_enb_4 = enb_q;
  assign mem_enb_5 = enb_q;
  assign mem_enb_6 = enb_q;
  assign mem_rst_0 = rst;
  assign mem_rst_1 = rst;
  assign mem_rst_2 = rst;
  assign mem_rst_3 = rst;
  assign mem_rst_4 = rst;
  assign mem_rst_5 = rst;
  assign mem_rst_6 = rst;

  assign unused_s = ^{cfg_wint_q, cfg_irst_q, i_conf_kernelsize[15:0], i_conf_kernelshape[31:8],
                      i_conf_kernelshape[3:0], i_conf_inputshape[15:8], i_conf_ctrl[31:5],
                      i_conf_ctrl[3:1], mem_odat_6, mem_odat_0[31:24], mem_odat_1[31:24],
                      mem_odat_2[31:24], mem_odat_3[31:24], mem_odat_4[31:24]};

endmodule

// File: tb/tb_dnn_accel_core.sv
// Bench for dnn_accel_core: the memories are address-hashed or constant models, and expected
// results come from a direct per-pixel convolution model.
module tb_dnn_accel_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] cfg_ctrl = 32'd0;
  logic [31:0] outsize_cfg = 32'd0;
  logic [15:0] npass_cfg = 16'd1;
  logic [7:0]  w_cfg = 8'd3;
  logic [15:0] lg2s_cfg = 16'd0;
  logic [31:0] o_conf_status;
  logic [31:0] mem_addr_0, mem_addr_1, mem_addr_2, mem_addr_3, mem_addr_4, mem_addr_5, mem_addr_6;
  logic [31:0] mem_idat_0, mem_idat_1, mem_idat_2, mem_idat_3, mem_idat_4, mem_idat_5, mem_idat_6;
  logic [31:0] mem_odat_0, mem_odat_1, mem_odat_2, mem_odat_3, mem_odat_4, mem_odat_5;
  logic [31:0] mem_odat_6 = 32'd0;
  logic [3:0]  mem_wren_0, mem_wren_1, mem_wren_2, mem_wren_3, mem_wren_4, mem_wren_5, mem_wren_6;
  logic mem_enb_0, mem_enb_1, mem_enb_2, mem_enb_3, mem_enb_4, mem_enb_5, mem_enb_6;
  logic mem_rst_0, mem_rst_1, mem_rst_2, mem_rst_3, mem_rst_4, mem_rst_5, mem_rst_6;

  int vectors = 0;
  int errors = 0;
  bit rand_mode = 1'b0;
  bit acc_mode = 1'b0;
  logic [31:0] const_word [6];
  logic [31:0] seed [6];
  logic [31:0] last_wdata;
  logic [31:0] cap_tap [9];
  logic [31:0] cap_w0, cap_w8, cap_o;

  always #5 clk = ~clk;

  dnn_accel_core dut (
    .clk(clk), .rst(rst),
    .i_conf_ctrl(cfg_ctrl), .i_conf_outputsize(outsize_cfg),
    .i_conf_kernelsize({npass_cfg, 16'd9}), .i_conf_weightinterval(32'h0000_0009),
    .i_conf_kernelshape(32'h0004_0333), .i_conf_inputshape({lg2s_cfg, 8'd3, w_cfg}),
    .i_conf_inputrstcnt(32'd0), .o_conf_status(o_conf_status),
    .mem_addr_0(mem_addr_0), .mem_idat_0(mem_idat_0), .mem_odat_0(mem_odat_0), .mem_wren_0(mem_wren_0), .mem_enb_0(mem_enb_0), .mem_rst_0(mem_rst_0),
    .mem_addr_1(mem_addr_1), .mem_idat_1(mem_idat_1), .mem_odat_1(mem_odat_1), .mem_wren_1(mem_wren_1), .mem_enb_1(mem_enb_1), .mem_rst_1(mem_rst_1),
    .mem_addr_2(mem_addr_2), .mem_idat_2(mem_idat_2), .mem_odat_2(mem_odat_2), .mem_wren_2(mem_wren_2), .mem_enb_2(mem_enb_2), .mem_rst_2(mem_rst_2),
    .mem_addr_3(mem_addr_3), .mem_idat_3(mem_idat_3), .mem_odat_3(mem_odat_3), .mem_wren_3(mem_wren_3), .mem_enb_3(mem_enb_3), .mem_rst_3(mem_rst_3),
    .mem_addr_4(mem_addr_4), .mem_idat_4(mem_idat_4), .mem_odat_4(mem_odat_4), .mem_wren_4(mem_wren_4), .mem_enb_4(mem_enb_4), .mem_rst_4(mem_rst_4),
    .mem_addr_5(mem_addr_5), .mem_idat_5(mem_idat_5), .mem_odat_5(mem_odat_5), .mem_wren_5(mem_wren_5), .mem_enb_5(mem_enb_5), .mem_rst_5(mem_rst_5),
    .mem_addr_6(mem_addr_6), .mem_idat_6(mem_idat_6), .mem_odat_6(mem_odat_6), .mem_wren_6(mem_wren_6), .mem_enb_6(mem_enb_6), .mem_rst_6(mem_rst_6)
  );

  function automatic logic [31:0] mem_word(input int port, input logic [31:0] addr);
    logic [31:0] h;
    if (!rand_mode) return const_word[port];
    h = addr * 32'h9E37_79B1 + seed[port];
    h = h ^ (h >> 15);
    h = h * 32'h85EB_CA6B;
    return h ^ (h >> 13);
  endfunction

  // Synchronous-read memories: data appears the cycle after the address
  always @(posedge clk) begin
    if (mem_enb_0) mem_odat_0 <= mem_word(0, mem_addr_0);
    if (mem_enb_1) mem_odat_1 <= mem_word(1, mem_addr_1);
    if (mem_enb_2) mem_odat_2 <= mem_word(2, mem_addr_2);
    if (mem_enb_3) mem_odat_3 <= mem_word(3, mem_addr_3);
    if (mem_enb_4) mem_odat_4 <= mem_word(4, mem_addr_4);
    if (mem_enb_5) mem_odat_5 <= mem_word(5, mem_addr_5);
  end

  function automatic int sb(input logic [31:0] w, input int i);
    logic signed [7:0] b;
    b = w[i*8 +: 8];
    return int'(b);
  endfunction

  function automatic int out_w();
    return ((int'(w_cfg) - 3) >>> int'(lg2s_cfg)) + 1;
  endfunction

  function automatic logic [31:0] tap_addr(input int pix, input int k);
    int s, ox, oy;
    s = 1 << int'(lg2s_cfg);
    ox = pix % out_w();
    oy = pix / out_w();
    return 32'((oy * s + k / 3) * int'(w_cfg) + ox * s + k % 3);
  endfunction

  function automatic logic [31:0] ref_pixel(input int pass, input int pix);
    logic [31:0] r, v32, d, w;
    int acc, outn;
    outn = int'(outsize_cfg) + 1;
    r = 32'd0;
    for (int n = 0; n < 4; n++) begin
      acc = 0;
      for (int k = 0; k < 9; k++) begin
        d = mem_word(0, tap_addr(pix, k));
        w = mem_word(n + 1, 32'(pass * 9 + k));
        for (int c = 0; c < 3; c++) acc += sb(d, c) * sb(w, c);
      end
      if (acc_mode) acc += sb(mem_word(5, 32'(pass * outn + pix)), n);
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
      v32 = 32'(acc);
      r[n*8 +: 8] = v32[7:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // Start a job and check every cycle against the slot model; abort_at >= 0 clears enable at that cycle
  task automatic run_job(input int abort_at);
    int total, outn, slot, t, pass, pix;
    outn = int'(outsize_cfg) + 1;
    total = int'(npass_cfg) * outn * 11;
    cfg_ctrl = acc_mode ? 32'h11 : 32'h01;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      slot = c / 11; t = c % 11; pass = slot / outn; pix = slot % outn;
      chk("busy", o_conf_status, 32'h1);
      chk("enb", {25'd0, mem_enb_6, mem_enb_5, mem_enb_4, mem_enb_3, mem_enb_2, mem_enb_1, mem_enb_0}, 32'h7F);
      chk("rd_wren", {8'd0, mem_wren_5, mem_wren_4, mem_wren_3, mem_wren_2, mem_wren_1, mem_wren_0}, 32'd0);
      chk("rd_idat", mem_idat_0 | mem_idat_1 | mem_idat_2 | mem_idat_3 | mem_idat_4 | mem_idat_5, 32'd0);
      if (t <= 8) begin
        chk("tap_addr", mem_addr_0, tap_addr(pix, t));
        chk("wgt_addr1", mem_addr_1, 32'(pass * 9 + t));
        chk("wgt_addr4", mem_addr_4, 32'(pass * 9 + t));
        if (slot == 1) cap_tap[t] = mem_addr_0;
        if (slot == outn && t == 0) cap_w0 = mem_addr_1;
        if (slot == outn && t == 8) cap_w8 = mem_addr_1;
      end
      if (t == 0) chk("psum_addr", mem_addr_5, 32'(pass * outn + pix));
      if (t == 10) begin
        chk("wren", {28'd0, mem_wren_6}, 32'hF);
        chk("out_addr", mem_addr_6, 32'(pass * outn + pix));
        chk("out_data", mem_idat_6, ref_pixel(pass, pix));
        last_wdata = mem_idat_6;
        if (slot == outn) cap_o = mem_addr_6;
      end else begin
        chk("wren_off", {28'd0, mem_wren_6}, 32'd0);
      end
      if (c == abort_at) begin
        cfg_ctrl = 32'd0;
        break;
      end
    end
    if (abort_at < 0) begin
      @(negedge clk);
      chk("done", o_conf_status, 32'h2);
      chk("done_enb", {31'd0, mem_enb_0}, 32'd0);
      chk("done_wren", {28'd0, mem_wren_6}, 32'd0);
      repeat (2) begin
        @(negedge clk);
        chk("done_hold", o_conf_status, 32'h2);
      end
      cfg_ctrl = 32'd0;
      @(negedge clk);
      chk("idle", o_conf_status, 32'd0);
    end else begin
      repeat (15) begin
        @(negedge clk);
        chk("abort_status", o_conf_status, 32'd0);
        chk("abort_wren", {28'd0, mem_wren_6}, 32'd0);
      end
    end
  endtask

  task automatic rand_cfg(input int min_out);
    rand_mode = 1'b1;
    for (int p = 0; p < 6; p++) seed[p] = $urandom;
    w_cfg = 8'($urandom_range(20, 3));
    lg2s_cfg = 16'($urandom_range(1, 0));
    outsize_cfg = 32'($urandom_range(30, min_out));
    npass_cfg = 16'($urandom_range(3, 1));
    acc_mode = 1'($urandom_range(1, 0));
  endtask

  task automatic const_job(input logic [31:0] pixw, input logic [31:0] wgtw, input logic [31:0] psw,
                           input bit acc, input logic [31:0] req, input string tag);
    rand_mode = 1'b0;
    const_word[0] = pixw;
    for (int p = 1; p < 5; p++) const_word[p] = wgtw;
    const_word[5] = psw;
    w_cfg = 8'd3; lg2s_cfg = 16'd0; outsize_cfg = 32'd0; npass_cfg = 16'd1; acc_mode = acc;
    run_job(-1);
    chk(tag, last_wdata, req);
  endtask

  initial begin
    logic [31:0] exp_taps [9];
    exp_taps = '{32'd2, 32'd3, 32'd4, 32'd226, 32'd227, 32'd228, 32'd450, 32'd451, 32'd452};
    for (int p = 0; p < 6; p++) begin const_word[p] = 32'd0; seed[p] = 32'd0; end
    repeat (2) @(negedge clk);
    chk("rst_status", o_conf_status, 32'd0);
    chk("rst_wren", {28'd0, mem_wren_6}, 32'd0);
    chk("rst_addr", mem_addr_0 | mem_addr_1 | mem_addr_5 | mem_addr_6, 32'd0);
    chk("rst_memrst", {31'd0, mem_rst_0 & mem_rst_6}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("memrst_low", {31'd0, mem_rst_0 | mem_rst_6}, 32'd0);
    chk("idle_status", o_conf_status, 32'd0);

    const_job(32'h0101_0101, 32'h0202_0202, 32'd0, 1'b0, 32'h3636_3636, "single_pixel");
    const_job(32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'd0, 1'b0, 32'h7F7F_7F7F, "sat_pos");
    const_job(32'h7F7F_7F7F, 32'h8181_8181, 32'd0, 1'b0, 32'h8080_8080, "sat_neg");
    const_job(32'h0101_0101, 32'h0202_0202, 32'h0101_0101, 1'b1, 32'h3737_3737, "accumulate");

    // Zero passes: straight to DONE without touching memory
    npass_cfg = 16'd0;
    cfg_ctrl = 32'h1;
    @(negedge clk);
    chk("p0_done", o_conf_status, 32'h2);
    chk("p0_enb", {31'd0, mem_enb_0 | mem_enb_6}, 32'd0);
    chk("p0_wren", {28'd0, mem_wren_6}, 32'd0);
    cfg_ctrl = 32'd0;
    @(negedge clk);
    chk("p0_idle", o_conf_status, 32'd0);

    rand_cfg(0);
    w_cfg = 8'd224; lg2s_cfg = 16'd1; outsize_cfg = 32'd120; npass_cfg = 16'd2;
    run_job(-1);
    for (int i = 0; i < 9; i++) chk("stride_tap", cap_tap[i], exp_taps[i]);
    chk("pass1_wgt_first", cap_w0, 32'd9);
    chk("pass1_wgt_last", cap_w8, 32'd17);
    chk("pass1_out_first", cap_o, 32'd121);

    repeat (3) begin
      rand_cfg(0);
      run_job(-1);
    end

    // Abort on the drain cycle of pixel 4, then restart the same job from scratch
    rand_cfg(8);
    run_job(53);
    run_job(-1);

    // Asynchronous reset while a write is on the bus
    rand_cfg(8);
    cfg_ctrl = 32'h1;
    repeat (22) @(negedge clk);
    chk("pre_rst_wren", {28'd0, mem_wren_6}, 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("async_wren", {28'd0, mem_wren_6}, 32'd0);
    chk("async_status", o_conf_status, 32'd0);
    chk("async_enb", {31'd0, mem_enb_0}, 32'd0);
    chk("async_addr", mem_addr_0 | mem_addr_6, 32'd0);
    cfg_ctrl = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", o_conf_status, 32'd0);
    run_job(-1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
